// File: rtl/fft_peak_seeker_if.sv
// Bundle of the magnitude stream, frame control, RAM port pair and peak result for
// fft_peak_seeker.
interface fft_peak_seeker_if #(
  parameter int unsigned ADDR_W = 6,
  parameter int unsigned DATA_W = 32
);
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              frame_abort;
  logic              ram_cea;
  logic [ADDR_W-1:0] ram_ada;
  logic [DATA_W-1:0] ram_din;
  logic              ram_ceb;
  logic              ram_oce;
  logic [ADDR_W-1:0] ram_adb;
  logic [DATA_W-1:0] ram_dout;
  logic              peak_valid;
  logic [ADDR_W-1:0] peak_idx;
  logic [DATA_W-1:0] peak_mag;
  logic              busy;
  logic [15:0]       frame_cnt;

  modport master (
    output in_valid, in_data, frame_abort, ram_dout,
    input  in_ready, ram_cea, ram_ada, ram_din, ram_ceb, ram_oce, ram_adb,
    input  peak_valid, peak_idx, peak_mag, busy, frame_cnt
  );

  modport slave (
    input  in_valid, in_data, frame_abort, ram_dout,
    output in_ready, ram_cea, ram_ada, ram_din, ram_ceb, ram_oce, ram_adb,
    output peak_valid, peak_idx, peak_mag, busy, frame_cnt
  );
endinterface

// File: rtl/fft_peak_seeker.sv
// Buffers one FFT magnitude frame into an external RAM, then scans bins BIN_LO..BIN_HI
// for the largest magnitude and reports its index and value.
module fft_peak_seeker #(
  parameter int unsigned ADDR_W = 6,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned BIN_LO = 1,
  parameter int unsigned BIN_HI = 63
) (
  input logic             clk,
  input logic             rst_n,
  fft_peak_seeker_if.slave bus
);

  typedef enum logic [1:0] {StFill, StScan, StFlush, StReport} state_e;

  localparam logic [ADDR_W-1:0] LoAddr = ADDR_W'(BIN_LO);
  localparam logic [ADDR_W-1:0] HiAddr = ADDR_W'(BIN_HI);
  localparam logic [ADDR_W-1:0] LastWr = '1;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] wr_cnt_q, wr_cnt_d;
  logic [ADDR_W-1:0] rd_cnt_q, rd_cnt_d;
  logic [ADDR_W-1:0] rd_adr_q;
  logic              rd_vld_q, rd_vld_d;
  logic [DATA_W-1:0] best_mag_q, best_mag_d;
  logic [ADDR_W-1:0] best_idx_q, best_idx_d;
  logic [DATA_W-1:0] peak_mag_q, peak_mag_d;
  logic [ADDR_W-1:0] peak_idx_q, peak_idx_d;
  logic [15:0]       frame_cnt_q, frame_cnt_d;
  logic              accept;
  logic              report;

  assign bus.in_ready = (state_q == StFill) & ~bus.frame_abort;
  assign accept       = bus.in_valid & bus.in_ready;
  assign bus.ram_cea  = accept;
  assign bus.ram_ada  = accept ? wr_cnt_q : '0;
  assign bus.ram_din  = accept ? bus.in_data : '0;
  assign bus.ram_ceb  = (state_q == StScan);
  assign bus.ram_oce  = (state_q == StScan);
  assign bus.ram_adb  = bus.ram_ceb ? rd_cnt_q : '0;

  // Result is presented during the REPORT cycle itself so an abort there can veto it.
  assign report         = (state_q == StReport) & ~bus.frame_abort;
  assign bus.peak_valid = report;
  assign bus.peak_idx   = report ? best_idx_q : peak_idx_q;
  assign bus.peak_mag   = report ? best_mag_q : peak_mag_q;
  assign bus.busy       = (state_q != StFill);
  assign bus.frame_cnt  = frame_cnt_q;

  always_comb begin
    state_d     = state_q;
    wr_cnt_d    = wr_cnt_q;
    rd_cnt_d    = rd_cnt_q;
    rd_vld_d    = 1'b0;
    best_mag_d  = best_mag_q;
    best_idx_d  = best_idx_q;
    peak_mag_d  = peak_mag_q;
    peak_idx_d  = peak_idx_q;
    frame_cnt_d = frame_cnt_q;

    // Strict compare keeps the lowest index on ties.
    if (rd_vld_q && (bus.ram_dout > best_mag_q)) begin
      best_mag_d = bus.ram_dout;
      best_idx_d = rd_adr_q;
    end

    unique case (state_q)
      StFill: begin
        if (accept) begin
          wr_cnt_d = wr_cnt_q + 1'b1;
          if (wr_cnt_q == LastWr) begin
            state_d    = StScan;
            rd_cnt_d   = LoAddr;
            best_mag_d = '0;
            best_idx_d = LoAddr;
          end
        end
      end
      StScan: begin
        rd_vld_d = 1'b1;
        rd_cnt_d = rd_cnt_q + 1'b1;
        if (rd_cnt_q == HiAddr) begin
          state_d  = StFlush;
          rd_cnt_d = LoAddr;
        end
      end
      StFlush: state_d = StReport;
      StReport: begin
        state_d     = StFill;
        peak_mag_d  = best_mag_q;
        peak_idx_d  = best_idx_q;
        frame_cnt_d = frame_cnt_q + 16'd1;
      end
      default: state_d = StFill;
    endcase

    if (bus.frame_abort) begin
      state_d     = StFill;
      wr_cnt_d    = '0;
      rd_cnt_d    = LoAddr;
      rd_vld_d    = 1'b0;
      peak_mag_d  = peak_mag_q;
      peak_idx_d  = peak_idx_q;
      frame_cnt_d = frame_cnt_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StFill;
      wr_cnt_q    <= '0;
      rd_cnt_q    <= LoAddr;
      rd_adr_q    <= '0;
      rd_vld_q    <= 1'b0;
      best_mag_q  <= '0;
      best_idx_q  <= LoAddr;
      peak_mag_q  <= '0;
      peak_idx_q  <= '0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wr_cnt_q    <= wr_cnt_d;
      rd_cnt_q    <= rd_cnt_d;
      rd_adr_q    <= rd_cnt_q;
      rd_vld_q    <= rd_vld_d;
      best_mag_q  <= best_mag_d;
      best_idx_q  <= best_idx_d;
      peak_mag_q  <= peak_mag_d;
      peak_idx_q  <= peak_idx_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

endmodule
